// File: rtl/reg_snapshot_viewer.sv
// reg_snapshot_viewer: debug-view core between CPU register taps and a character display.
// It holds a snapshot of NUM_CH channels (live, frozen or single-step capture) under PS/2
// set-2 make-code control, pages through the channels, and serves upper-case hex ASCII
// through a registered row/col read port with one cycle of latency.
// Optional feature: define CHANGE_HILITE_EN to keep a previous-capture copy and flag the
// digits that changed (rd_hilite); when it is undefined rd_hilite is tied low.
module reg_snapshot_viewer #(
    parameter int NUM_CH        = 16,
    parameter int DATA_W        = 32,
    parameter int ROWS_PER_PAGE = 8,
    localparam int NUM_PAGES = (NUM_CH + ROWS_PER_PAGE - 1) / ROWS_PER_PAGE,
    localparam int DIGITS    = DATA_W / 4,
    localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
    localparam int ROW_W     = (ROWS_PER_PAGE > 1) ? $clog2(ROWS_PER_PAGE) : 1,
    localparam int COL_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     kb_valid,
    input  logic [7:0]               kb_code,
    input  logic [ROW_W-1:0]         rd_row,
    input  logic [COL_W-1:0]         rd_col,
    output logic [7:0]               rd_char,
    output logic                     rd_hilite,
    output logic [PAGE_W-1:0]        page,
    output logic                     frozen,
    output logic [7:0]               snap_cnt
);
    // Wide enough for page*ROWS_PER_PAGE + any rd_row without wrapping.
    localparam int CH_W = PAGE_W + ROW_W + $clog2(ROWS_PER_PAGE + 1) + 1;

    typedef enum logic [1:0] {K_IDLE, K_BREAK, K_EXT} key_t;
    typedef enum logic {CAP_LIVE, CAP_FROZEN} cap_t;

    key_t              key_q, key_nxt;
    cap_t              cap_q, cap_nxt;
    logic              cmd_f, cmd_l, cmd_s, cmd_d, cmd_u;
    logic              load_snap;
    logic [PAGE_W-1:0] page_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] snap_q [NUM_CH];
`ifdef CHANGE_HILITE_EN
    logic [DATA_W-1:0] prev_q [NUM_CH];
`endif
    logic [CH_W-1:0]   rd_ch;
    logic [7:0]        char_nxt, char_q;
    logic              hil_nxt, hil_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Key decoder and capture-mode next state; commands only fire from make codes in IDLE.
    always_comb begin
        key_nxt = key_q;
        cap_nxt = cap_q;
        cmd_f   = 1'b0;
        cmd_l   = 1'b0;
        cmd_s   = 1'b0;
        cmd_d   = 1'b0;
        cmd_u   = 1'b0;
        if (kb_valid) begin
            case (key_q)
                K_IDLE: begin
                    if (kb_code == 8'hF0) begin
                        key_nxt = K_BREAK;
                    end else if (kb_code == 8'hE0) begin
                        key_nxt = K_EXT;
                    end else begin
                        case (kb_code)
                            8'h2B:   cmd_f = 1'b1;
                            8'h4B:   cmd_l = 1'b1;
                            8'h1B:   cmd_s = 1'b1;
                            8'h23:   cmd_d = 1'b1;
                            8'h3C:   cmd_u = 1'b1;
                            default: ;
                        endcase
                    end
                end
                K_BREAK: key_nxt = K_IDLE;
                K_EXT:   key_nxt = (kb_code == 8'hF0) ? K_BREAK : K_IDLE;
                default: key_nxt = K_IDLE;
            endcase
        end
        if (cmd_l) begin
            cap_nxt = CAP_LIVE;
        end else if (cmd_f || cmd_s) begin
            cap_nxt = CAP_FROZEN;
        end
        // In LIVE the snapshot loads every edge, which also covers the F decode edge.
        load_snap = (cap_q == CAP_LIVE) || cmd_s;
    end

    // Control state: key FSM, capture mode, page and single-step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= K_IDLE;
            cap_q  <= CAP_LIVE;
            page_q <= '0;
            cnt_q  <= 8'h00;
        end else begin
            key_q <= key_nxt;
            cap_q <= cap_nxt;
            if (cmd_d) begin
                page_q <= (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
            end else if (cmd_u) begin
                page_q <= (page_q == '0) ? PAGE_W'(NUM_PAGES - 1) : page_q - 1'b1;
            end
            if (cmd_s) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Snapshot storage (and its one-capture-old copy when change highlighting is built in).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
`ifdef CHANGE_HILITE_EN
                prev_q[k] <= '0;
`endif
            end
        end else if (load_snap) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= ch_data[k*DATA_W +: DATA_W];
`ifdef CHANGE_HILITE_EN
                prev_q[k] <= snap_q[k];
`endif
            end
        end
    end

    assign rd_ch = CH_W'(page_q) * CH_W'(ROWS_PER_PAGE) + CH_W'(rd_row);

    // Read-port lookup: select channel and digit, convert to ASCII, blank when out of range.
    always_comb begin
        logic              ch_ok, col_ok;
        logic [DATA_W-1:0] word;
        logic [3:0]        nib;
`ifdef CHANGE_HILITE_EN
        logic [DATA_W-1:0] word_prev;
        logic [3:0]        nib_prev;
        word_prev = '0;
        nib_prev  = 4'h0;
`endif
        ch_ok    = 1'b0;
        col_ok   = 1'b0;
        word     = '0;
        nib      = 4'h0;
        char_nxt = 8'h20;
        hil_nxt  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_ch == CH_W'(k)) begin
                ch_ok = 1'b1;
                word  = snap_q[k];
`ifdef CHANGE_HILITE_EN
                word_prev = prev_q[k];
`endif
            end
        end
        for (int d = 0; d < DIGITS; d++) begin
            if (rd_col == COL_W'(d)) begin
                col_ok = 1'b1;
                nib    = word[DATA_W-1-4*d -: 4];
`ifdef CHANGE_HILITE_EN
                nib_prev = word_prev[DATA_W-1-4*d -: 4];
`endif
            end
        end
        if (ch_ok && col_ok) begin
            char_nxt = hex_ascii(nib);
`ifdef CHANGE_HILITE_EN
            hil_nxt = (nib != nib_prev);
`endif
        end
    end

    // Registered read port: one cycle of latency, sees the pre-capture snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_q <= 8'h00;
            hil_q  <= 1'b0;
        end else begin
            char_q <= char_nxt;
            hil_q  <= hil_nxt;
        end
    end

    assign rd_char   = char_q;
    assign rd_hilite = hil_q;
    assign page      = page_q;
    assign frozen    = (cap_q == CAP_FROZEN);
    assign snap_cnt  = cnt_q;

endmodule
